// File: rtl/ray_dispatch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ray_dispatch_scheduler_pkg
//  Purpose  : Shared types and default constants for the primary-ray
//             dispatch scheduler and the per-core thread-data generators.
//  Revision : 1.0  initial release
// ============================================================================
package ray_dispatch_scheduler_pkg;

   // Default geometry and core count, also reused by the thread generators
   localparam int RDS_NUM_CORES = 4;
   localparam int RDS_FB_W      = 160;
   localparam int RDS_FB_H      = 120;
   localparam int RDS_COORD_W   = 10;

   // Scheduler state encoding
   typedef enum logic [1:0] {
      SDS_Idle = 2'd0,
      SDS_Scan = 2'd1,
      SDS_Done = 2'd2
   } sds_state_t;

endpackage : ray_dispatch_scheduler_pkg
`default_nettype wire

// File: rtl/ray_dispatch_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : ray_dispatch_scheduler_if
//  Purpose  : Dispatch bus between the scheduler (master) and the ray-core
//             thread-data generators (slave). Strobe only, no ready; cores
//             signal back-pressure through their FIFO-full flags.
//  Revision : 1.0  initial release
// ============================================================================
interface ray_dispatch_scheduler_if
   import ray_dispatch_scheduler_pkg::*;
#(
   parameter int NUM_CORES = RDS_NUM_CORES,
   parameter int COORD_W   = RDS_COORD_W
);
   logic [NUM_CORES-1:0] core_full;
   logic [NUM_CORES-1:0] dispatch_valid;
   logic [COORD_W-1:0]   dispatch_x;
   logic [COORD_W-1:0]   dispatch_y;

   modport master (
      input  core_full,
      output dispatch_valid,
      output dispatch_x,
      output dispatch_y
   );

   modport slave (
      output core_full,
      input  dispatch_valid,
      input  dispatch_x,
      input  dispatch_y
   );
endinterface : ray_dispatch_scheduler_if
`default_nettype wire

// File: rtl/ray_dispatch_scheduler_rr_core_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_core_pick
//  Purpose  : Rotating-priority encoder. Returns the first core whose FIFO is
//             not full, searching ptr, ptr+1, ... wrapping modulo NUM_CORES.
//  Revision : 1.0  initial release
// ============================================================================
module rr_core_pick #(
   parameter int NUM_CORES = 4,
   parameter int PTR_W     = 2
) (
   input  wire logic [NUM_CORES-1:0] core_full,
   input  wire logic [PTR_W-1:0]     ptr,
   output logic                      found,
   output logic [PTR_W-1:0]          idx
);

   // Scan from the farthest offset down so the nearest free core wins last
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr) + k) % NUM_CORES;
         if (!core_full[j]) begin
            found = 1'b1;
            idx   = PTR_W'(j);
         end
      end
   end

endmodule : rr_core_pick
`default_nettype wire

// File: rtl/ray_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ray_dispatch_scheduler
//  Purpose  : Walks a clipped screen region in row-major order and hands each
//             pixel coordinate to exactly one ray core, rotating priority
//             among cores and skipping those whose input FIFO is full.
//  Revision : 1.0  initial release
// ============================================================================
module ray_dispatch_scheduler
   import ray_dispatch_scheduler_pkg::*;
#(
   parameter int NUM_CORES = RDS_NUM_CORES,
   parameter int FB_W      = RDS_FB_W,
   parameter int FB_H      = RDS_FB_H,
   parameter int COORD_W   = RDS_COORD_W
) (
   input  wire logic                   clk,
   input  wire logic                   resetn,
   input  wire logic                   start,
   input  wire logic                   abort,
   input  wire logic [COORD_W-1:0]     region_x0,
   input  wire logic [COORD_W-1:0]     region_y0,
   input  wire logic [COORD_W-1:0]     region_w,
   input  wire logic [COORD_W-1:0]     region_h,
   ray_dispatch_scheduler_if.master    dsp,
   output logic                        busy,
   output logic                        frame_done,
   output logic [2*COORD_W-1:0]        dispatched_count
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [COORD_W:0] c_FB_W_EXT = (COORD_W+1)'(FB_W);
   localparam logic [COORD_W:0] c_FB_H_EXT = (COORD_W+1)'(FB_H);
   localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(NUM_CORES - 1);

   sds_state_t             r_state;
   logic [COORD_W-1:0]     r_x0;
   logic [COORD_W:0]       r_x_end;
   logic [COORD_W:0]       r_y_end;
   logic [COORD_W-1:0]     r_cx;
   logic [COORD_W-1:0]     r_cy;
   logic [PTR_W-1:0]       r_ptr;
   logic [NUM_CORES-1:0]   r_valid;
   logic [COORD_W-1:0]     r_dx;
   logic [COORD_W-1:0]     r_dy;
   logic                   r_frame_done;
   logic [2*COORD_W-1:0]   r_count;

   logic [COORD_W:0]       w_x_sum;
   logic [COORD_W:0]       w_y_sum;
   logic [COORD_W:0]       w_x_end;
   logic [COORD_W:0]       w_y_end;
   logic                   w_region_empty;
   logic [COORD_W:0]       w_cx_inc;
   logic [COORD_W:0]       w_cy_inc;
   logic                   w_found;
   logic [PTR_W-1:0]       w_idx;
   logic [PTR_W-1:0]       w_ptr_next;

   // Region end computed one bit wider so x0+w cannot wrap before clipping
   assign w_x_sum        = {1'b0, region_x0} + {1'b0, region_w};
   assign w_y_sum        = {1'b0, region_y0} + {1'b0, region_h};
   assign w_x_end        = (w_x_sum > c_FB_W_EXT) ? c_FB_W_EXT : w_x_sum;
   assign w_y_end        = (w_y_sum > c_FB_H_EXT) ? c_FB_H_EXT : w_y_sum;
   assign w_region_empty = ({1'b0, region_x0} >= w_x_end) ||
                           ({1'b0, region_y0} >= w_y_end);

   assign w_cx_inc   = {1'b0, r_cx} + (COORD_W+1)'(1);
   assign w_cy_inc   = {1'b0, r_cy} + (COORD_W+1)'(1);
   assign w_ptr_next = (w_idx == c_PTR_LAST) ? '0 : w_idx + PTR_W'(1);

   rr_core_pick #(
      .NUM_CORES (NUM_CORES),
      .PTR_W     (PTR_W)
   ) u_pick (
      .core_full (dsp.core_full),
      .ptr       (r_ptr),
      .found     (w_found),
      .idx       (w_idx)
   );

   // Scheduler FSM: region latch, row-major walk, and registered dispatch outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= SDS_Idle;
         r_x0         <= '0;
         r_x_end      <= '0;
         r_y_end      <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_ptr        <= '0;
         r_valid      <= '0;
         r_dx         <= '0;
         r_dy         <= '0;
         r_frame_done <= 1'b0;
         r_count      <= '0;
      end else begin
         r_valid      <= '0;
         r_frame_done <= 1'b0;
         if (abort) begin
            r_state <= SDS_Idle;
         end else begin
            case (r_state)
               SDS_Idle: begin
                  if (start) begin
                     r_x0    <= region_x0;
                     r_x_end <= w_x_end;
                     r_y_end <= w_y_end;
                     if (w_region_empty) begin
                        r_state <= SDS_Done;
                     end else begin
                        r_cx    <= region_x0;
                        r_cy    <= region_y0;
                        r_count <= '0;
                        r_state <= SDS_Scan;
                     end
                  end
               end
               SDS_Scan: begin
                  if (w_found) begin
                     r_valid <= NUM_CORES'(1) << w_idx;
                     r_dx    <= r_cx;
                     r_dy    <= r_cy;
                     r_ptr   <= w_ptr_next;
                     r_count <= r_count + (2*COORD_W)'(1);
                     if (w_cx_inc == r_x_end) begin
                        r_cx <= r_x0;
                        r_cy <= COORD_W'(w_cy_inc);
                        if (w_cy_inc == r_y_end) begin
                           r_state <= SDS_Done;
                        end
                     end else begin
                        r_cx <= COORD_W'(w_cx_inc);
                     end
                  end
               end
               SDS_Done: begin
                  r_frame_done <= 1'b1;
                  r_state      <= SDS_Idle;
               end
               default: r_state <= SDS_Idle;
            endcase
         end
      end
   end

   assign dsp.dispatch_valid = r_valid;
   assign dsp.dispatch_x     = r_dx;
   assign dsp.dispatch_y     = r_dy;
   assign busy               = (r_state != SDS_Idle);
   assign frame_done         = r_frame_done;
   assign dispatched_count   = r_count;

endmodule : ray_dispatch_scheduler
`default_nettype wire

// File: tb/tb_ray_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ray_dispatch_scheduler
//  Purpose  : Directed self-checking bench for ray_dispatch_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ray_dispatch_scheduler;

   localparam int NC = 4;
   localparam int CW = 10;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [CW-1:0]  region_x0 = '0;
   logic [CW-1:0]  region_y0 = '0;
   logic [CW-1:0]  region_w  = '0;
   logic [CW-1:0]  region_h  = '0;
   logic           busy;
   logic           frame_done;
   logic [2*CW-1:0] dispatched_count;

   int checks = 0;
   int passes = 0;

   ray_dispatch_scheduler_if #(.NUM_CORES(NC), .COORD_W(CW)) dsp_if ();

   ray_dispatch_scheduler #(
      .NUM_CORES (NC),
      .FB_W      (160),
      .FB_H      (120),
      .COORD_W   (CW)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .start            (start),
      .abort            (abort),
      .region_x0        (region_x0),
      .region_y0        (region_y0),
      .region_w         (region_w),
      .region_h         (region_h),
      .dsp              (dsp_if.master),
      .busy             (busy),
      .frame_done       (frame_done),
      .dispatched_count (dispatched_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock and settle just past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int x0, input int y0, input int w, input int h);
      region_x0 = CW'(x0);
      region_y0 = CW'(y0);
      region_w  = CW'(w);
      region_h  = CW'(h);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic chk_disp(input string tag, input logic [NC-1:0] v, input int x, input int y);
      chk({tag, "_valid"}, 64'(dsp_if.dispatch_valid), 64'(v));
      chk({tag, "_x"}, 64'(dsp_if.dispatch_x), 64'(x));
      chk({tag, "_y"}, 64'(dsp_if.dispatch_y), 64'(y));
   endtask

   initial begin
      int ex, ey, ndisp, cyc;
      logic seen_done;
      dsp_if.core_full = '0;

      // Reset values
      #12;
      chk("rst_valid", 64'(dsp_if.dispatch_valid), 64'(0));
      chk("rst_x", 64'(dsp_if.dispatch_x), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(frame_done), 64'(0));
      chk("rst_count", 64'(dispatched_count), 64'(0));
      resetn = 1'b1;
      step();

      // 2x2 region, no back-pressure
      go(10, 20, 2, 2);
      chk("t1_busy", 64'(busy), 64'(1));
      chk("t1_v0", 64'(dsp_if.dispatch_valid), 64'(0));
      step(); chk_disp("t1_d0", 4'b0001, 10, 20);
      step(); chk_disp("t1_d1", 4'b0010, 11, 20);
      step(); chk_disp("t1_d2", 4'b0100, 10, 21);
      step(); chk_disp("t1_d3", 4'b1000, 11, 21);
      chk("t1_count", 64'(dispatched_count), 64'(4));
      chk("t1_done_early", 64'(frame_done), 64'(0));
      step();
      chk("t1_done", 64'(frame_done), 64'(1));
      chk("t1_vdone", 64'(dsp_if.dispatch_valid), 64'(0));
      step();
      chk("t1_done_pulse", 64'(frame_done), 64'(0));
      chk("t1_idle", 64'(busy), 64'(0));

      // Core 1 held full: cores 0,2,3,0
      dsp_if.core_full = 4'b0010;
      go(10, 20, 2, 2);
      step(); chk_disp("t2_d0", 4'b0001, 10, 20);
      step(); chk_disp("t2_d1", 4'b0100, 11, 20);
      step(); chk_disp("t2_d2", 4'b1000, 10, 21);
      step(); chk_disp("t2_d3", 4'b0001, 11, 21);
      step(); chk("t2_done", 64'(frame_done), 64'(1));
      dsp_if.core_full = '0;
      step();

      // All cores full for 3 cycles mid-region; pointer is at core 1
      go(10, 20, 2, 2);
      step(); chk_disp("t3_d0", 4'b0010, 10, 20);
      dsp_if.core_full = 4'b1111;
      step(); chk_disp("t3_stall0", 4'b0000, 10, 20);
      step(); chk_disp("t3_stall1", 4'b0000, 10, 20);
      step(); chk_disp("t3_stall2", 4'b0000, 10, 20);
      chk("t3_stall_count", 64'(dispatched_count), 64'(1));
      dsp_if.core_full = '0;
      step(); chk_disp("t3_d1", 4'b0100, 11, 20);
      step(); chk_disp("t3_d2", 4'b1000, 10, 21);
      step(); chk_disp("t3_d3", 4'b0001, 11, 21);
      step(); chk("t3_done", 64'(frame_done), 64'(1));
      step();

      // Region clipped by the framebuffer edge: 10x10 pixels
      go(150, 110, 20, 20);
      ex = 150; ey = 110; ndisp = 0; cyc = 0; seen_done = 1'b0;
      while (!seen_done && cyc < 300) begin
         step();
         cyc++;
         if (dsp_if.dispatch_valid != '0) begin
            chk("t4_x", 64'(dsp_if.dispatch_x), 64'(ex));
            chk("t4_y", 64'(dsp_if.dispatch_y), 64'(ey));
            ndisp++;
            ex++;
            if (ex == 160) begin
               ex = 150;
               ey++;
            end
         end
         if (frame_done) seen_done = 1'b1;
      end
      chk("t4_seen_done", 64'(seen_done), 64'(1));
      chk("t4_ndisp", 64'(ndisp), 64'(100));
      chk("t4_count", 64'(dispatched_count), 64'(100));
      step();

      // Zero-width region: one busy cycle, then frame_done, no dispatches
      go(5, 5, 0, 3);
      chk("t5_busy", 64'(busy), 64'(1));
      chk("t5_v0", 64'(dsp_if.dispatch_valid), 64'(0));
      step();
      chk("t5_done", 64'(frame_done), 64'(1));
      chk("t5_idle", 64'(busy), 64'(0));
      chk("t5_v1", 64'(dsp_if.dispatch_valid), 64'(0));
      chk("t5_count", 64'(dispatched_count), 64'(100));
      step();

      // Start and abort together while idle: remain idle
      abort = 1'b1;
      go(0, 0, 4, 4);
      abort = 1'b0;
      chk("t6_sa_idle", 64'(busy), 64'(0));

      // Abort after three dispatches of a 4x4 region (pointer at core 1)
      go(0, 0, 4, 4);
      step(); chk_disp("t6_d0", 4'b0010, 0, 0);
      step(); chk_disp("t6_d1", 4'b0100, 1, 0);
      step(); chk_disp("t6_d2", 4'b1000, 2, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_ab_busy", 64'(busy), 64'(0));
      chk("t6_ab_valid", 64'(dsp_if.dispatch_valid), 64'(0));
      chk("t6_ab_done", 64'(frame_done), 64'(0));
      step();
      chk("t6_ab_done2", 64'(frame_done), 64'(0));

      // Restart: origin again, count cleared, pointer continues at core 0
      go(0, 0, 4, 4);
      chk("t7_busy", 64'(busy), 64'(1));
      chk("t7_count0", 64'(dispatched_count), 64'(0));
      step(); chk_disp("t7_d0", 4'b0001, 0, 0);
      chk("t7_count1", 64'(dispatched_count), 64'(1));
      step(); chk_disp("t7_d1", 4'b0010, 1, 0);

      // Reset mid-scan returns to reset values without frame_done
      #2 resetn = 1'b0;
      #1;
      chk("t8_rst_busy", 64'(busy), 64'(0));
      chk("t8_rst_valid", 64'(dsp_if.dispatch_valid), 64'(0));
      chk("t8_rst_count", 64'(dispatched_count), 64'(0));
      chk("t8_rst_done", 64'(frame_done), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_ray_dispatch_scheduler
`default_nettype wire

// File: doc/ray_dispatch_scheduler.md
Name: ray_dispatch_scheduler

Overview:
- Sequences per-pixel primary-ray thread dispatch across the ray cores for a rectangular screen region.
- Walks the region in row-major order and hands each pixel coordinate to exactly one ray core.
- Shares the coordinate stream among cores with rotating priority, skipping cores whose input FIFO is full.
- Sits between the frame controller (start/abort, region) and the per-core thread-data generators.

Parameters:
- NUM_CORES, 4, number of ray cores served (2..16)
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- COORD_W, 10, screen coordinate width in bits

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  single-cycle request to begin a region; ignored unless idle
- abort  in  1  synchronous cancel of the current region
- region_x0  in  COORD_W  region left column, sampled on accepted start
- region_y0  in  COORD_W  region top row, sampled on accepted start
- region_w  in  COORD_W  region width, sampled on accepted start
- region_h  in  COORD_W  region height, sampled on accepted start
- core_full  in  NUM_CORES  per-core input FIFO full flags
- dispatch_valid  out  NUM_CORES  one-hot (or zero) dispatch strobe, registered
- dispatch_x  out  COORD_W  pixel column for the strobed core, registered
- dispatch_y  out  COORD_W  pixel row for the strobed core, registered
- busy  out  1  high while not idle
- frame_done  out  1  one-cycle pulse when the last pixel has been dispatched
- dispatched_count  out  2*COORD_W  pixels dispatched in the current or last region

Behaviour:
- Reset (asynchronous, active-low, clk domain): state IDLE; dispatch_valid=0; dispatch_x/y=0; busy=0; frame_done=0; dispatched_count=0; rotating pointer=0.
- States:
  - IDLE: on start, latch the region and clip it: x_end=min(x0+w,FB_W), y_end=min(y0+h,FB_H).
    - If x0>=x_end or y0>=y_end, go to DONE.
    - Otherwise set cx=x0, cy=y0, clear dispatched_count, go to SCAN.
  - SCAN: each cycle, pick the first core i with core_full[i]==0, searching ptr, ptr+1, ... mod NUM_CORES.
    - If one is found, register dispatch_valid=onehot(i), dispatch_x=cx, dispatch_y=cy; set ptr=(i+1) mod NUM_CORES; increment dispatched_count.
    - Then advance cx. If cx+1==x_end, set cx=x0 and cy=cy+1. If cy+1 also ==y_end, go to DONE.
    - If all cores are full, dispatch_valid=0 and cx, cy, ptr hold.
  - DONE: frame_done=1 for exactly one cycle, dispatch_valid=0, then go to IDLE.
- Timing and handshake:
  - Accepted start at edge N gives the first dispatch_valid at edge N+1.
  - Throughput is at most one pixel per cycle.
  - core_full is sampled at the same edge that registers the dispatch.
  - A core must accept any strobe it receives; the strobe has no ready.
  - dispatch_valid is zero in every cycle outside SCAN.
- busy=1 in SCAN and DONE, otherwise 0.
- start while busy: ignored.
- abort in any state: next edge gives IDLE, dispatch_valid=0, no frame_done. abort has priority over start and over progress in SCAN in the same cycle.
- start and abort together while IDLE: stay IDLE.
- Width rules: x0+w and y0+h are computed at COORD_W+1 bits before clipping. dispatched_count wraps modulo 2^(2*COORD_W).
- Reset mid-SCAN: immediate return to reset values; no partial frame_done.

Decomposition:
- Shared package holds:
  - the scheduler state enum (SDS_Idle, SDS_Scan, SDS_Done)
  - the NUM_CORES / FB_W / FB_H constants reused by the thread generators
- One combinational sub-module, rr_core_pick: inputs core_full and ptr; outputs found and the chosen index. Rotating-priority encoder.

Test Plan:
- Region (10,20,2,2), NUM_CORES=4, no full → valid 0001,0010,0100,1000 on consecutive cycles with (10,20),(11,20),(10,21),(11,21); frame_done next cycle; dispatched_count=4.
- Same region, core_full=0010 held → cores 0,2,3,0 receive (10,20),(11,20),(10,21),(11,21).
- All core_full=1111 for 3 cycles mid-region → no valid for 3 cycles, coordinates frozen; resume at the held pixel on the pointed core.
- Region (150,110,20,20) with FB 160x120 → exactly 100 dispatches, x in 150..159, y in 110..119, then frame_done.
- region_w=0 → busy for 1 cycle, frame_done 1 cycle after start, zero dispatches.
- abort after 3 dispatches of a 4x4 region → IDLE next cycle, no frame_done. A new start restarts at region origin with count=0.
